// File: rtl/arc4_pkg.sv
// Shared types for the ARC4 decrypt datapath: S-box depth, byte type and
// the PRGA state encoding.
package arc4_pkg;

    localparam int S_DEPTH = 256;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_LEN,
        ST_CALC_I,
        ST_RD_SI,
        ST_CALC_J,
        ST_RD_SJ,
        ST_WR_SJ,
        ST_WR_SI,
        ST_RD_SIJ,
        ST_DROP,
        ST_RD_CT,
        ST_WAIT_CT,
        ST_WR_PT,
        ST_INC_K
    } prga_state_t;

endpackage

// File: rtl/rc4_prga_drop.sv
// RC4 keystream generator with optional RC4-drop[N]: copies a little-endian
// length header from ct to pt, then writes pt = ct ^ keystream per byte.
module rc4_prga_drop
    import arc4_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int LEN_BYTES = 2,
    parameter int DROP_N    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    output logic [7:0]        s_addr,
    input  logic [7:0]        s_rddata,
    output logic [7:0]        s_wrdata,
    output logic              s_wren,
    output logic [ADDR_W-1:0] ct_addr,
    input  logic [7:0]        ct_rddata,
    output logic [ADDR_W-1:0] pt_addr,
    output logic [7:0]        pt_wrdata,
    output logic              pt_wren
);

    localparam int LEN_W   = ADDR_W + 1;
    localparam int HDR_W   = 8 * LEN_BYTES;
    localparam int MAX_LEN = (1 << ADDR_W) - LEN_BYTES;

    prga_state_t      state_q, state_d;
    byte_t            i_q, i_d, j_q, j_d;
    byte_t            si_q, si_d, sj_q, sj_d, ks_q, ks_d;
    logic [LEN_W-1:0] k_q, k_d, len_q, len_d, k_inc, len_clamped;
    logic [10:0]      dropped_q, dropped_d;
    logic [HDR_W-1:0] hdr_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            si_q      <= '0;
            sj_q      <= '0;
            ks_q      <= '0;
            k_q       <= '0;
            len_q     <= '0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            si_q      <= si_d;
            sj_q      <= sj_d;
            ks_q      <= ks_d;
            k_q       <= k_d;
            len_q     <= len_d;
            dropped_q <= dropped_d;
        end
    end

    // The last header byte is on ct_rddata; earlier (low) byte sits in len_q.
    always_comb begin
        hdr_raw     = HDR_W'(len_q[7:0]) | (HDR_W'(ct_rddata) << (8 * (LEN_BYTES - 1)));
        len_clamped = (32'(hdr_raw) > MAX_LEN) ? LEN_W'(MAX_LEN) : LEN_W'(hdr_raw);
        k_inc       = k_q + LEN_W'(1);
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        si_d      = si_q;
        sj_d      = sj_q;
        ks_d      = ks_q;
        k_d       = k_q;
        len_d     = len_q;
        dropped_d = dropped_q;
        rdy       = (state_q == ST_IDLE);
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        ct_addr   = '0;
        pt_addr   = '0;
        pt_wrdata = '0;
        pt_wren   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d   = ST_RD_LEN;
                    i_d       = '0;
                    j_d       = '0;
                    k_d       = '0;
                    len_d     = '0;
                    dropped_d = '0;
                end
            end
            // k indexes header bytes here: read byte k, echo byte k-1.
            ST_RD_LEN: begin
                if (k_q < LEN_W'(LEN_BYTES)) ct_addr = ADDR_W'(k_q);
                if (k_q != '0) begin
                    pt_addr   = ADDR_W'(k_q - LEN_W'(1));
                    pt_wrdata = ct_rddata;
                    pt_wren   = 1'b1;
                end
                if (k_q == LEN_W'(LEN_BYTES)) begin
                    len_d   = len_clamped;
                    k_d     = '0;
                    state_d = (hdr_raw == '0) ? ST_IDLE : ST_CALC_I;
                end else begin
                    if (k_q != '0) len_d = LEN_W'(ct_rddata);
                    k_d = k_inc;
                end
            end
            ST_CALC_I: begin
                i_d     = i_q + 8'd1;
                state_d = ST_RD_SI;
            end
            ST_RD_SI: begin
                s_addr  = i_q;
                state_d = ST_CALC_J;
            end
            ST_CALC_J: begin
                si_d    = s_rddata;
                j_d     = j_q + s_rddata;
                state_d = ST_RD_SJ;
            end
            ST_RD_SJ: begin
                s_addr  = j_q;
                state_d = ST_WR_SJ;
            end
            ST_WR_SJ: begin
                sj_d     = s_rddata;
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                state_d  = ST_WR_SI;
            end
            ST_WR_SI: begin
                s_addr   = i_q;
                s_wrdata = sj_q;
                s_wren   = 1'b1;
                state_d  = ST_RD_SIJ;
            end
            ST_RD_SIJ: begin
                s_addr  = si_q + sj_q;
                state_d = (dropped_q < 11'(DROP_N)) ? ST_DROP : ST_RD_CT;
            end
            ST_DROP: begin
                dropped_d = dropped_q + 11'd1;
                state_d   = ST_CALC_I;
            end
            ST_RD_CT: begin
                ks_d    = s_rddata;
                ct_addr = ADDR_W'(k_q + LEN_W'(LEN_BYTES));
                state_d = ST_WAIT_CT;
            end
            // ks_q is folded with the ciphertext so it holds the plaintext byte.
            ST_WAIT_CT: begin
                ks_d    = ks_q ^ ct_rddata;
                state_d = ST_WR_PT;
            end
            ST_WR_PT: begin
                pt_addr   = ADDR_W'(k_q + LEN_W'(LEN_BYTES));
                pt_wrdata = ks_q;
                pt_wren   = 1'b1;
                state_d   = ST_INC_K;
            end
            ST_INC_K: begin
                k_d     = k_inc;
                state_d = (k_inc < len_q) ? ST_CALC_I : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rc4_prga_drop.sv
// Bench for rc4_prga_drop: three parameterisations side by side, memories
// modelled in the stimulus process, results compared with an RC4 reference.
module tb_rc4_prga_drop;

    localparam int NI    = 3;
    localparam int AW    = 9;
    localparam int MEMSZ = 512;

    int lb_of [NI] = '{1, 1, 2};
    int dn_of [NI] = '{0, 2, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          en [NI], rdy [NI], s_wren [NI], pt_wren [NI];
    logic [7:0]    s_addr [NI], s_rddata [NI], s_wrdata [NI];
    logic [7:0]    ct_rddata [NI], pt_wrdata [NI];
    logic [AW-1:0] ct_addr [NI], pt_addr [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LB = (g == 2) ? 2 : 1;
        localparam int DN = (g == 1) ? 2 : 0;
        rc4_prga_drop #(.ADDR_W(AW), .LEN_BYTES(LB), .DROP_N(DN)) u_dut (
            .clk(clk), .rst(rst), .en(en[g]), .rdy(rdy[g]),
            .s_addr(s_addr[g]), .s_rddata(s_rddata[g]), .s_wrdata(s_wrdata[g]), .s_wren(s_wren[g]),
            .ct_addr(ct_addr[g]), .ct_rddata(ct_rddata[g]),
            .pt_addr(pt_addr[g]), .pt_wrdata(pt_wrdata[g]), .pt_wren(pt_wren[g])
        );
    end

    logic [7:0]    smem [NI][256];
    logic [7:0]    ctm [NI][MEMSZ];
    logic [7:0]    ptm [NI][MEMSZ];
    logic [7:0]    cs_addr [NI], cs_wrdata [NI], cpt_wrdata [NI];
    logic [AW-1:0] cct_addr [NI], cpt_addr [NI];
    logic          cs_wren [NI], cpt_wren [NI];
    int            n_ptw [NI], n_sw [NI], n_ct [NI], n_gl [NI], last_pta [NI];

    logic [7:0] exp_pt [MEMSZ];
    logic [7:0] exp_s [256];
    int         exp_len;

    int o_ptw, o_sw, o_ct, o_gl, o_lastpta, o_ptbad, o_sbad;
    bit o_done, o_rdy1;

    int checks = 0;
    int errors = 0;

    task automatic capture();
        for (int g = 0; g < NI; g++) begin
            cs_addr[g]    = s_addr[g];
            cs_wrdata[g]  = s_wrdata[g];
            cs_wren[g]    = s_wren[g];
            cct_addr[g]   = ct_addr[g];
            cpt_addr[g]   = pt_addr[g];
            cpt_wrdata[g] = pt_wrdata[g];
            cpt_wren[g]   = pt_wren[g];
        end
    endtask

    task automatic count();
        for (int g = 0; g < NI; g++) begin
            if (pt_wren[g]) begin
                n_ptw[g]++;
                last_pta[g] = int'(pt_addr[g]);
            end
            if (s_wren[g]) n_sw[g]++;
            if (ct_addr[g] != '0) n_ct[g]++;
            if ((!s_wren[g] && s_wrdata[g] != 8'd0) || (!pt_wren[g] && pt_wrdata[g] != 8'd0))
                n_gl[g]++;
        end
    endtask

    // Synchronous memories: data for the address seen this cycle appears after the edge.
    task automatic mem_update();
        for (int g = 0; g < NI; g++) begin
            s_rddata[g]  = smem[g][cs_addr[g]];
            ct_rddata[g] = ctm[g][cct_addr[g]];
            if (cs_wren[g]) smem[g][cs_addr[g]] = cs_wrdata[g];
            if (cpt_wren[g]) ptm[g][cpt_addr[g]] = cpt_wrdata[g];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_update();
        @(negedge clk);
        capture();
        count();
    endtask

    task automatic load_identity(input int g);
        for (int n = 0; n < 256; n++) smem[g][n] = 8'(n);
    endtask

    task automatic load_perm(input int g);
        logic [7:0] t;
        int r;
        load_identity(g);
        for (int n = 255; n > 0; n--) begin
            r = $urandom_range(n, 0);
            t = smem[g][n];
            smem[g][n] = smem[g][r];
            smem[g][r] = t;
        end
    endtask

    task automatic load_ct(input int g, input int hdr, input int plen);
        for (int n = 0; n < MEMSZ; n++) ctm[g][n] = 8'($urandom);
        ctm[g][0] = 8'(hdr);
        if (lb_of[g] == 2) ctm[g][1] = 8'(hdr >> 8);
        if (plen >= 0) ctm[g][lb_of[g]] = ctm[g][lb_of[g]];
    endtask

    // Textbook RC4 PRGA over a copy of S, skipping dn_of[g] keystream bytes.
    task automatic ref_model(input int g);
        logic [7:0] s [256];
        logic [7:0] i, j, t, idx;
        int hdr, len, lb, dn;
        lb  = lb_of[g];
        dn  = dn_of[g];
        for (int n = 0; n < 256; n++) s[n] = smem[g][n];
        hdr = int'(ctm[g][0]);
        if (lb == 2) hdr += int'(ctm[g][1]) * 256;
        len = (hdr > MEMSZ - lb) ? MEMSZ - lb : hdr;
        for (int n = 0; n < lb; n++) exp_pt[n] = ctm[g][n];
        i = 8'd0;
        j = 8'd0;
        if (len > 0) begin
            for (int n = 0; n < dn + len; n++) begin
                i = i + 8'd1;
                j = j + s[i];
                t = s[i]; s[i] = s[j]; s[j] = t;
                idx = s[i] + s[j];
                if (n >= dn) exp_pt[lb + n - dn] = s[idx] ^ ctm[g][lb + n - dn];
            end
        end
        for (int n = 0; n < 256; n++) exp_s[n] = s[n];
        exp_len = len;
    endtask

    task automatic do_run(input int g, input bit busy_en);
        int b_ptw, b_sw, b_ct, b_gl, budget;
        ref_model(g);
        for (int n = 0; n < MEMSZ; n++) ptm[g][n] = 8'hEE;
        b_ptw  = n_ptw[g];
        b_sw   = n_sw[g];
        b_ct   = n_ct[g];
        b_gl   = n_gl[g];
        budget = 20 * (exp_len + dn_of[g]) + 40;
        en[g] = 1'b1;
        tick();
        en[g] = 1'b0;
        o_rdy1 = rdy[g];
        o_done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (rdy[g]) begin
                o_done = 1'b1;
                break;
            end
            if (busy_en) en[g] = (c == 4);
            tick();
        end
        en[g] = 1'b0;
        o_ptw     = n_ptw[g] - b_ptw;
        o_sw      = n_sw[g] - b_sw;
        o_ct      = n_ct[g] - b_ct;
        o_gl      = n_gl[g] - b_gl;
        o_lastpta = last_pta[g];
        o_ptbad   = 0;
        for (int n = 0; n < lb_of[g] + exp_len; n++)
            if (ptm[g][n] !== exp_pt[n]) o_ptbad++;
        o_sbad = 0;
        for (int n = 0; n < 256; n++)
            if (smem[g][n] !== exp_s[n]) o_sbad++;
    endtask

    task automatic test_reset();
        for (int g = 0; g < NI; g++) begin
            checks++;
            if (rdy[g] !== 1'b1) begin
                errors++;
                $display("FAIL reset_rdy[%0d] got %b want 1", g, rdy[g]);
            end
            checks++;
            if ({s_addr[g], s_wrdata[g], s_wren[g], ct_addr[g], pt_addr[g], pt_wrdata[g], pt_wren[g]} !== 44'd0) begin
                errors++;
                $display("FAIL reset_outs[%0d] got %h want 0", g,
                    {s_addr[g], s_wrdata[g], s_wren[g], ct_addr[g], pt_addr[g], pt_wrdata[g], pt_wren[g]});
            end
        end
    endtask

    task automatic test_known_vector();
        load_identity(0);
        load_ct(0, 2, 0);
        ctm[0][1] = 8'hAA;
        ctm[0][2] = 8'h55;
        do_run(0, 1'b0);
        checks++;
        if (o_rdy1 !== 1'b0) begin errors++; $display("FAIL kv_rdy_clear got %b want 0", o_rdy1); end
        checks++;
        if (!o_done) begin errors++; $display("FAIL kv_done timeout"); end
        checks++;
        if ({ptm[0][0], ptm[0][1], ptm[0][2]} !== 24'h02A850) begin
            errors++;
            $display("FAIL kv_pt got %h want 02a850", {ptm[0][0], ptm[0][1], ptm[0][2]});
        end
        checks++;
        if ({smem[0][2], smem[0][3]} !== 16'h0302) begin
            errors++;
            $display("FAIL kv_sbox got %h want 0302", {smem[0][2], smem[0][3]});
        end
        checks++;
        if (o_ptw !== 3 || o_gl !== 0) begin
            errors++;
            $display("FAIL kv_writes got ptw=%0d glitch=%0d want 3/0", o_ptw, o_gl);
        end
    endtask

    task automatic test_drop();
        load_identity(1);
        load_ct(1, 1, 0);
        ctm[1][1] = 8'h00;
        do_run(1, 1'b0);
        checks++;
        if (!o_done || ptm[1][1] !== 8'h07) begin
            errors++;
            $display("FAIL drop_pt got %h done=%b want 07", ptm[1][1], o_done);
        end
        checks++;
        if (o_ct !== 1 || o_ptw !== 2 || o_sw !== 6) begin
            errors++;
            $display("FAIL drop_access got ct=%0d ptw=%0d sw=%0d want 1/2/6", o_ct, o_ptw, o_sw);
        end
    endtask

    task automatic test_len300();
        load_perm(2);
        load_ct(2, 300, 0);
        do_run(2, 1'b0);
        checks++;
        if (!o_done || o_ptw !== 302 || o_lastpta !== 301) begin
            errors++;
            $display("FAIL len300_writes got done=%b ptw=%0d last=%0d want 1/302/301", o_done, o_ptw, o_lastpta);
        end
        checks++;
        if (o_ptbad !== 0 || o_sbad !== 0) begin
            errors++;
            $display("FAIL len300_data got ptbad=%0d sbad=%0d want 0/0", o_ptbad, o_sbad);
        end
    endtask

    task automatic test_zero_len();
        load_perm(0);
        load_ct(0, 0, 0);
        do_run(0, 1'b0);
        checks++;
        if (!o_done || o_ptw !== 1 || o_sw !== 0 || ptm[0][0] !== 8'h00 || ptm[0][1] !== 8'hEE) begin
            errors++;
            $display("FAIL zero_len got done=%b ptw=%0d sw=%0d pt0=%h pt1=%h want 1/1/0/00/ee",
                o_done, o_ptw, o_sw, ptm[0][0], ptm[0][1]);
        end
    endtask

    task automatic test_clamp();
        load_perm(2);
        load_ct(2, 16'hFFFF, 0);
        do_run(2, 1'b0);
        checks++;
        if (!o_done || o_ptw !== 512 || o_lastpta !== 511) begin
            errors++;
            $display("FAIL clamp_writes got done=%b ptw=%0d last=%0d want 1/512/511", o_done, o_ptw, o_lastpta);
        end
        checks++;
        if (ptm[2][0] !== 8'hFF || ptm[2][1] !== 8'hFF || o_ptbad !== 0) begin
            errors++;
            $display("FAIL clamp_data got hdr=%h%h ptbad=%0d want ffff/0", ptm[2][1], ptm[2][0], o_ptbad);
        end
    endtask

    task automatic test_busy_en();
        load_perm(1);
        load_ct(1, $urandom_range(40, 5), 0);
        do_run(1, 1'b1);
        checks++;
        if (!o_done || o_ptw !== 1 + exp_len || o_ptbad !== 0 || o_sbad !== 0) begin
            errors++;
            $display("FAIL busy_en got done=%b ptw=%0d ptbad=%0d sbad=%0d want 1/%0d/0/0",
                o_done, o_ptw, o_ptbad, o_sbad, 1 + exp_len);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int g;
            int len;
            g   = r % NI;
            len = (r < 3) ? 1 : $urandom_range(60, 2);
            load_perm(g);
            load_ct(g, len, 0);
            do_run(g, 1'b0);
            checks++;
            if (!o_done || o_ptw !== lb_of[g] + exp_len || o_ptbad !== 0 || o_sbad !== 0 || o_gl !== 0) begin
                errors++;
                $display("FAIL random[%0d] inst=%0d len=%0d got done=%b ptw=%0d ptbad=%0d sbad=%0d glitch=%0d",
                    r, g, len, o_done, o_ptw, o_ptbad, o_sbad, o_gl);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int base;
        bit hit;
        load_identity(0);
        load_ct(0, 10, 0);
        base = n_sw[0];
        hit  = 1'b0;
        en[0] = 1'b1;
        tick();
        en[0] = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (n_sw[0] - base == 9) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!hit || s_wren[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrun_reach got hit=%b wren=%b want 1/1", hit, s_wren[0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rdy[0] !== 1'b1 || {s_addr[0], s_wrdata[0], s_wren[0], ct_addr[0], pt_addr[0], pt_wrdata[0], pt_wren[0]} !== 44'd0) begin
            errors++;
            $display("FAIL midrun_abort got rdy=%b outs=%h want 1/0", rdy[0],
                {s_addr[0], s_wrdata[0], s_wren[0], ct_addr[0], pt_addr[0], pt_wrdata[0], pt_wren[0]});
        end
        capture();
        tick();
        tick();
        rst = 1'b0;
        tick();
        load_identity(0);
        load_ct(0, $urandom_range(30, 8), 0);
        do_run(0, 1'b0);
        checks++;
        if (!o_done || o_ptw !== 1 + exp_len || o_ptbad !== 0 || o_sbad !== 0) begin
            errors++;
            $display("FAIL midrun_rerun got done=%b ptw=%0d ptbad=%0d sbad=%0d want 1/%0d/0/0",
                o_done, o_ptw, o_ptbad, o_sbad, 1 + exp_len);
        end
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            en[g]        = 1'b0;
            s_rddata[g]  = 8'd0;
            ct_rddata[g] = 8'd0;
            n_ptw[g]     = 0;
            n_sw[g]      = 0;
            n_ct[g]      = 0;
            n_gl[g]      = 0;
            last_pta[g]  = 0;
            load_identity(g);
            for (int n = 0; n < MEMSZ; n++) begin
                ctm[g][n] = 8'd0;
                ptm[g][n] = 8'd0;
            end
        end
        rst = 1'b1;
        @(negedge clk);
        capture();
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        tick();
        test_known_vector();
        test_drop();
        test_len300();
        test_zero_len();
        test_clamp();
        test_busy_en();
        test_random();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
